// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT result unloader.
// FFT_BITREV_REORDER_EN (see fft_result_unloader) selects bit-reversed write addressing.
package fft_pkg;

  localparam int unsigned LOG2N = 9;
  localparam int unsigned N     = 1 << LOG2N;
  localparam int unsigned DW    = 32;

  typedef logic [DW-1:0]    fft_word_t;
  typedef logic [LOG2N-1:0] fft_idx_t;

  localparam fft_idx_t IdxLast = fft_idx_t'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} fft_state_t;

  function automatic fft_idx_t bitrev(fft_idx_t idx);
    fft_idx_t r;
    r = '0;
    for (int b = 0; b < int'(LOG2N); b++) begin
      r[b] = idx[int'(LOG2N) - 1 - b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port N x DW frame buffer: one write port, one synchronous read port.
// Contents are not reset; the read register holds its value while i_re is low.
module fft_frame_ram
  import fft_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_we,
  input  fft_idx_t  i_waddr,
  input  fft_word_t i_wdata,
  input  logic      i_re,
  input  fft_idx_t  i_raddr,
  output fft_word_t o_rdata
);

  fft_word_t mem_q [N];
  fft_word_t rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/fft_result_unloader.sv
// Buffers one frame of FFT results and streams it out in natural index order with an EOF bit.
// Define FFT_BITREV_REORDER_EN to store incoming words at the bit-reversed index.
module fft_result_unloader
  import fft_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_data,
  input  logic          i_data_valid,
  output logic          o_data_ready,
  output logic [DW:0]   o_data,
  output logic          o_data_valid,
  input  logic          i_data_ready,
  output logic          o_busy,
  output logic          o_frame_done
);

  fft_state_t state_q, state_d;

  fft_idx_t      wr_idx_q, wr_idx_d;
  fft_idx_t      rd_idx_q, rd_idx_d;
  logic          rd_done_q, rd_done_d;
  logic          rv_q, rv_d;
  logic          rv_last_q, rv_last_d;
  logic          out_valid_q, out_valid_d;
  logic [DW:0]   out_data_q, out_data_d;

  logic      wr_en, rd_en, out_load, accept, frame_done;
  fft_idx_t  waddr;
  fft_word_t rdata;

`ifdef FFT_BITREV_REORDER_EN
  assign waddr = bitrev(wr_idx_q);
`else
  assign waddr = wr_idx_q;
`endif

  assign wr_en      = (state_q == FILL) && i_data_valid;
  assign accept     = out_valid_q && i_data_ready;
  // The RAM read register acts as the prefetch slot; it drains into the output register.
  assign out_load   = rv_q && (!out_valid_q || accept);
  assign rd_en      = (state_q == DRAIN) && !rd_done_q && (!rv_q || out_load);
  assign frame_done = accept && out_data_q[DW];

  fft_frame_ram u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (waddr),
    .i_wdata (i_data),
    .i_re    (rd_en),
    .i_raddr (rd_idx_q),
    .o_rdata (rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FILL;
      FILL:    if (wr_en && (wr_idx_q == IdxLast)) state_d = DRAIN;
      DRAIN:   if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_data_ready = (state_q == FILL);
    o_busy       = (state_q != IDLE);
    o_data       = out_data_q;
    o_data_valid = out_valid_q;
    o_frame_done = frame_done;
  end

  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    rd_done_d   = rd_done_q;
    rv_d        = rv_q;
    rv_last_d   = rv_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (state_q != FILL) begin
      wr_idx_d = '0;
    end else if (wr_en) begin
      wr_idx_d = wr_idx_q + fft_idx_t'(1);
    end

    if (state_q != DRAIN) begin
      rd_idx_d    = '0;
      rd_done_d   = 1'b0;
      rv_d        = 1'b0;
      rv_last_d   = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (rd_en) begin
        rv_d      = 1'b1;
        rv_last_d = (rd_idx_q == IdxLast);
        // Hold at the last index so the counter never wraps inside DRAIN.
        if (rd_idx_q == IdxLast) begin
          rd_done_d = 1'b1;
        end else begin
          rd_idx_d = rd_idx_q + fft_idx_t'(1);
        end
      end else if (out_load) begin
        rv_d = 1'b0;
      end

      if (out_load) begin
        out_valid_d = 1'b1;
        out_data_d  = {rv_last_q, rdata};
      end else if (accept) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      rd_done_q   <= 1'b0;
      rv_q        <= 1'b0;
      rv_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rd_done_q   <= rd_done_d;
      rv_q        <= rv_d;
      rv_last_q   <= rv_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
